// File: rtl/rf_wb_sink.sv
// rtl/rf_wb_sink.sv - integer register file fed by write-back, two bypassed read ports
// Storage has no reset; a clear sequencer zeroes entries 1..N-1 after rst so it can map to distributed RAM.
module rf_wb_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_en_in,
  input  logic [ADDR_WIDTH-1:0] reg_write_addr_in,
  input  logic [DATA_WIDTH-1:0] reg_write_data_in,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rf_ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clr_idx;
  logic [ADDR_WIDTH-1:0]   clr_idx_next;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= FIRST_IDX;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // Single write port shared by the clear sequencer and write-back; rst blocks both.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    mem_we       = 1'b0;
    mem_waddr    = reg_write_addr_in;
    mem_wdata    = reg_write_data_in;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx;
        mem_wdata = '0;
        if (clr_idx == LAST_IDX) begin
          state_next = READY;
        end else begin
          clr_idx_next = clr_idx + FIRST_IDX;
        end
      end
      READY: begin
        mem_we = reg_write_en_in && (reg_write_addr_in != '0);
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign active   = !rst && (state == READY);
  assign rf_ready = active;

  always_comb begin
    rs1_data = '0;
    if (active && (rs1_addr != '0)) begin
      if (BYPASS_EN && reg_write_en_in && (reg_write_addr_in == rs1_addr)) begin
        rs1_data = reg_write_data_in;
      end else begin
        rs1_data = mem[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (active && (rs2_addr != '0)) begin
      if (BYPASS_EN && reg_write_en_in && (reg_write_addr_in == rs2_addr)) begin
        rs2_data = reg_write_data_in;
      end else begin
        rs2_data = mem[rs2_addr];
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_sink.sv
// tb/tb_rf_wb_sink.sv - directed bench for rf_wb_sink, bypass on and off instances
module tb_rf_wb_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        ready, ready_nb;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rf_wb_sink #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .reg_write_en_in(we), .reg_write_addr_in(waddr), .reg_write_data_in(wdata),
    .rs1_addr(ra1), .rs2_addr(ra2), .rs1_data(rd1), .rs2_data(rd2), .rf_ready(ready)
  );

  rf_wb_sink #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .reg_write_en_in(we), .reg_write_addr_in(waddr), .reg_write_data_in(wdata),
    .rs1_addr(ra1), .rs2_addr(ra2), .rs1_data(rd1_nb), .rs2_data(rd2_nb), .rf_ready(ready_nb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic clear_run(input string tag);
    for (int i = 1; i <= 31; i++) begin
      tick();
      check(tag, {31'd0, ready}, {31'd0, i == 31});
      check({tag, "_nb"}, {31'd0, ready_nb}, {31'd0, i == 31});
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; ra1 = 5'd5; ra2 = 5'd31;
    repeat (2) tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rd1", rd1, 32'd0);
    check("rst_rd2", rd2, 32'd0);

    // Clear sequence with a write attempt on clear edge 10
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      if (i == 10) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
      end
      tick();
      we = 1'b0;
      check("clr_ready", {31'd0, ready}, {31'd0, i == 31});
      check("clr_rd1", rd1, 32'd0);
      check("clr_rd2", rd2, 32'd0);
    end
    ra1 = 5'd3; #1;
    check("clr_write_dropped", rd1, 32'd0);
    check("clr_write_dropped_nb", rd1_nb, 32'd0);

    // Basic write/read
    ra1 = 5'd7; ra2 = 5'd7;
    write_reg(5'd7, 32'h12345678);
    #1;
    check("wr_rd1", rd1, 32'h12345678);
    check("wr_rd2", rd2, 32'h12345678);
    check("wr_rd1_nb", rd1_nb, 32'h12345678);

    // x0 protection
    ra1 = 5'd0; we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; #1;
    check("x0_same", rd1, 32'd0);
    tick();
    we = 1'b0; #1;
    check("x0_next", rd1, 32'd0);
    check("x0_next_nb", rd1_nb, 32'd0);

    // Bypass on both ports vs no-bypass instance
    write_reg(5'd9, 32'h00000001);
    ra1 = 5'd9; ra2 = 5'd9;
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; #1;
    check("byp_rd1", rd1, 32'hA5A5A5A5);
    check("byp_rd2", rd2, 32'hA5A5A5A5);
    check("nobyp_rd1", rd1_nb, 32'h00000001);
    check("nobyp_rd2", rd2_nb, 32'h00000001);
    ra2 = 5'd7; #1;
    check("byp_other_port", rd2, 32'h12345678);
    tick();
    we = 1'b0; #1;
    check("byp_next", rd1, 32'hA5A5A5A5);
    check("nobyp_next", rd1_nb, 32'hA5A5A5A5);

    // Reset mid-operation, then again mid-clear
    ra1 = 5'd4;
    write_reg(5'd4, 32'h00000055);
    #1;
    check("x4_written", rd1, 32'h00000055);
    rst = 1'b1; #1;
    check("rst_out_rd1", rd1, 32'd0);
    check("rst_out_ready", {31'd0, ready}, 32'd0);
    // rst has priority over a same-cycle write
    we = 1'b1; waddr = 5'd4; wdata = 32'h77777777;
    tick();
    we = 1'b0;
    rst = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check("mid_ready", {31'd0, ready}, 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_run("restart_ready");
    #1;
    check("x4_cleared", rd1, 32'd0);
    check("x4_cleared_nb", rd1_nb, 32'd0);
    check("x7_cleared", rd2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rf_wb_sink.md
Name: rf_wb_sink

Overview:
- Integer register file: the receiving end of the write-back interface (write enable, destination address, write data) driven by the WB stage.
- Provides two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- After reset, a clear sequencer zeroes the array one entry per cycle, so the storage can infer as distributed RAM instead of a reset flop array.
- Sits between the MEM/WB write-back outputs and ID-stage operand fetch.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns the write data; 0 = it returns the stored (old) value.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- reg_write_en_in  in  1  write strobe from WB.
- reg_write_addr_in  in  ADDR_WIDTH  destination register index.
- reg_write_data_in  in  DATA_WIDTH  data to write.
- rs1_addr  in  ADDR_WIDTH  read port 1 index.
- rs2_addr  in  ADDR_WIDTH  read port 2 index.
- rs1_data  out  DATA_WIDTH  read port 1 data (combinational).
- rs2_data  out  DATA_WIDTH  read port 2 data (combinational).
- rf_ready  out  1  high once the array clear is complete; the pipeline must stall while low.

Behaviour:
- The clock is clk. Reset rst is synchronous and active-high.
- FSM has two states: CLEAR and READY.
- Reset:
  - rst sampled high -> state=CLEAR, clr_idx=1, rf_ready=0.
  - Array contents are not cleared by rst itself.
  - All outputs are 0 while rst is high.
- CLEAR state:
  - Each edge with rst low writes 0 to mem[clr_idx], then clr_idx++.
  - On the edge that writes index 2**ADDR_WIDTH-1, state -> READY.
  - Default config: 31 clear edges after reset release; rf_ready rises after the 31st edge.
  - clr_idx must not wrap.
  - Index 0 is never stored; it reads as constant 0.
- CLEAR read/write rules:
  - reg_write_en_in is ignored; writes are dropped, not queued.
  - rs1_data and rs2_data = 0 regardless of address.
  - rst asserted mid-CLEAR restarts the sequence at clr_idx=1.
- READY state:
  - On an edge with reg_write_en_in=1 and reg_write_addr_in!=0: mem[reg_write_addr_in] <= reg_write_data_in.
  - Writes to index 0 are discarded.
  - State remains READY until rst.
- Read ports (READY):
  - rsN_data = 0 if rsN_addr==0.
  - Otherwise, if BYPASS_EN=1 and reg_write_en_in=1 and reg_write_addr_in==rsN_addr: rsN_data = reg_write_data_in.
  - Otherwise rsN_data = mem[rsN_addr].
  - Zero read latency; the bypass covers the WB-to-ID same-cycle hazard.
- Simultaneous events:
  - Both read ports may address the same register, including the one being written; each port resolves independently by the rules above.
  - rst has priority over any write in the same cycle.
- Widths: data is stored and returned unmodified, with no sign or zero extension.

Test Plan:
- Clear sequence: assert rst 2 cycles, release; rf_ready=0 for exactly 31 edges, then 1. Reading rs1_addr=5, rs2_addr=31 returns 0x00000000 both during and after CLEAR.
- Write during CLEAR dropped: write en=1, addr=3, data=0xDEADBEEF on cycle 10 of CLEAR. After READY, rs1_addr=3 reads 0x00000000.
- Basic write/read: in READY, write x7=0x12345678. Next cycle rs1_addr=7 and rs2_addr=7 both read 0x12345678.
- x0 protection: write x0=0xFFFFFFFF. Same cycle and next cycle, rs1_addr=0 reads 0x00000000.
- Bypass (BYPASS_EN=1): x9 holds 0x1; same cycle write x9=0xA5A5A5A5 with rs1_addr=9 -> rs1_data=0xA5A5A5A5. With BYPASS_EN=0 it reads 0x00000001 that cycle and 0xA5A5A5A5 the next.
- Reset mid-operation: after READY, write x4=0x55; assert rst during CLEAR cycle 15, release. rf_ready stays low for 31 further edges, and x4 reads 0 after READY.
